// File: rtl/gearbox_sched.sv
// 16-to-10-bit gearbox: five-phase residue scheduler with frame padding on in_last,
// feeding a small registered output FIFO drained under valid/ready backpressure.
module gearbox_sched #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  out_data,
  output logic        out_last,
  output logic [2:0]  phase
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    PH0 = 3'd0,
    PH1 = 3'd1,
    PH2 = 3'd2,
    PH3 = 3'd3,
    PH4 = 3'd4
  } phase_e;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // in_ready depends only on the registered occupancy, never on out_ready.

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] k);
    logic [PW+1:0] s;
    s = {2'b00, p} + {{PW{1'b0}}, k};
    if (s >= (PW+2)'(FIFO_DEPTH)) s = s - (PW+2)'(FIFO_DEPTH);
    return s[PW-1:0];
  endfunction

  phase_e         r_phase;
  phase_e         w_phase_nxt;
  phase_e         w_phase_adv;
  logic           r_run;
  logic [7:0]     r_res;
  logic [CW-1:0]  r_count;
  logic [PW-1:0]  r_wr;
  logic [PW-1:0]  r_rd;
  logic [9:0]     r_mem_data [FIFO_DEPTH];
  logic           r_mem_last [FIFO_DEPTH];

  logic           w_accept;
  logic           w_pop;
  logic [3:0]     w_res_len;
  logic [3:0]     w_res_len_nxt;
  logic [1:0]     w_nwords;
  logic [23:0]    w_comb;
  logic [7:0]     w_res_nxt;
  logic           w_pad;
  logic [1:0]     w_npush;
  logic [9:0]     w_slot_data [3];
  logic           w_slot_last [3];
  logic [PW-1:0]  w_wr_idx [3];

  // Internal enable released one edge after rst deasserts, so the first accept
  // lands on the second rising edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_run <= 1'b0;
    else      r_run <= 1'b1;
  end

  assign w_accept  = in_valid & in_ready & r_run;
  assign w_pop     = out_valid & out_ready;
  assign in_ready  = (r_count <= CW'(FIFO_DEPTH - 3));
  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem_data[r_rd] : 10'h000;
  assign out_last  = out_valid ? r_mem_last[r_rd] : 1'b0;
  assign phase     = r_phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_phase <= PH0;
    else      r_phase <= w_phase_nxt;
  end

  // Residue carried into each phase, words emitted, and residue left behind.
  always_comb begin
    w_res_len     = 4'd0;
    w_nwords      = 2'd1;
    w_res_len_nxt = 4'd6;
    w_phase_adv   = PH1;
    case (r_phase)
      PH0: begin w_res_len = 4'd0; w_nwords = 2'd1; w_res_len_nxt = 4'd6; w_phase_adv = PH1; end
      PH1: begin w_res_len = 4'd6; w_nwords = 2'd2; w_res_len_nxt = 4'd2; w_phase_adv = PH2; end
      PH2: begin w_res_len = 4'd2; w_nwords = 2'd1; w_res_len_nxt = 4'd8; w_phase_adv = PH3; end
      PH3: begin w_res_len = 4'd8; w_nwords = 2'd2; w_res_len_nxt = 4'd4; w_phase_adv = PH4; end
      PH4: begin w_res_len = 4'd4; w_nwords = 2'd2; w_res_len_nxt = 4'd0; w_phase_adv = PH0; end
      default: begin w_res_len = 4'd0; w_nwords = 2'd1; w_res_len_nxt = 4'd6; w_phase_adv = PH1; end
    endcase
    w_phase_nxt = r_phase;
    if (w_accept) w_phase_nxt = in_last ? PH0 : w_phase_adv;
  end

  // Bits above the live stream are zero, so the leftover residue is already zero-extended.
  assign w_comb    = ({8'd0, in_data} << w_res_len) | {16'd0, r_res};
  assign w_res_nxt = (w_nwords == 2'd2) ? {4'd0, w_comb[23:20]} : w_comb[17:10];
  assign w_pad     = in_last & (w_res_len_nxt != 4'd0);
  assign w_npush   = w_accept ? (w_nwords + {1'b0, w_pad}) : 2'd0;

  always_comb begin
    w_slot_data[0] = w_comb[9:0];
    w_slot_data[1] = (w_nwords == 2'd2) ? w_comb[19:10] : {2'b00, w_res_nxt};
    w_slot_data[2] = {2'b00, w_res_nxt};
    for (int i = 0; i < 3; i++) begin
      w_slot_last[i] = in_last & (w_npush == 2'(i + 1));
      w_wr_idx[i]    = ptr_add(r_wr, 2'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (w_npush > 2'(i)) begin
        r_mem_data[w_wr_idx[i]] <= w_slot_data[i];
        r_mem_last[w_wr_idx[i]] <= w_slot_last[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_res   <= 8'd0;
    end else begin
      r_count <= r_count + CW'(w_npush) - CW'(w_pop);
      r_wr    <= ptr_add(r_wr, w_npush);
      if (w_pop)    r_rd  <= ptr_add(r_rd, 2'd1);
      if (w_accept) r_res <= in_last ? 8'd0 : w_res_nxt;
    end
  end

endmodule

// File: tb/tb_gearbox_sched.sv
// Bench for gearbox_sched: a bit-queue stream model feeds an expected-word queue that a
// negedge monitor pops against the DUT output; occupancy and phase are checked alongside.
module tb_gearbox_sched;

  localparam int D = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_data;
  logic        out_last;
  logic [2:0]  phase;

  int checks   = 0;
  int failures = 0;
  int ready_mode = 1;
  int exp_phase  = 0;
  logic [10:0] exp_q[$];
  bit          bits_q[$];

  gearbox_sched #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: the stream as a flat LSB-first bit queue, cut into 10-bit words.
  task automatic model_accept(input logic [15:0] data, input logic last);
    logic [9:0] w;
    int n;
    for (int i = 0; i < 16; i++) bits_q.push_back(data[i]);
    while (bits_q.size() >= 10) begin
      for (int b = 0; b < 10; b++) w[b] = bits_q.pop_front();
      exp_q.push_back({1'b0, w});
    end
    if (last) begin
      if (bits_q.size() > 0) begin
        w = '0;
        n = bits_q.size();
        for (int b = 0; b < n; b++) w[b] = bits_q.pop_front();
        exp_q.push_back({1'b1, w});
      end else begin
        exp_q[exp_q.size() - 1] = exp_q[exp_q.size() - 1] | 11'h400;
      end
      exp_phase = 0;
    end else begin
      exp_phase = (exp_phase + 1) % 5;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] data, input logic last);
    int  n;
    bit  done;
    bit  ok;
    n = 0; done = 0; ok = 0;
    in_valid = 1'b1; in_data = data; in_last = last;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(data, last);
        done = 1; ok = 1;
      end else if (n >= 200) begin
        checks++; failures++;
        $display("FAIL send_timeout data=%h in_ready=%0b", data, in_ready);
        done = 1;
      end
      n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (ok) chk("phase", 32'(phase), 32'(exp_phase));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the expected queue whenever the DUT hands over a word.
  always @(negedge clk) begin
    logic [10:0] e;
    if (rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {21'd0, out_last, out_data}, 32'h7ff);
        end else begin
          e = exp_q.pop_front();
          chk("out_word", {21'd0, out_last, out_data}, {21'd0, e});
        end
      end else if (!out_valid) begin
        chk("empty_zero", {21'd0, out_last, out_data}, 32'd0);
      end
    end
  end

  // Occupancy: the expected queue length equals the DUT FIFO count just after each edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      chk("in_ready_occ", 32'(in_ready), 32'(exp_q.size() <= D - 3));
      chk("out_valid_occ", 32'(out_valid), 32'(exp_q.size() != 0));
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'd0);
    chk({tag, "_phase"},     32'(phase),     32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 16'($urandom);
      in_last  = 1'($urandom_range(0, 1));
      #3;
      reset_checks("hold_reset");
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);

    send(16'h1234, 1'b0);
    send(16'h5678, 1'b0);
    chk("order_phase2", 32'(phase), 32'd2);
    send(16'hABCD, 1'b1);
    wait_empty();

    for (int i = 0; i < 5; i++) send(16'hFFFF, 1'b0);
    chk("period_phase0", 32'(phase), 32'd0);
    wait_empty();

    send(16'h1234, 1'b1);
    wait_empty();

    for (int i = 0; i < 4; i++) send(16'($urandom), 1'b0);
    send(16'($urandom), 1'b1);
    wait_empty();

    ready_mode = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(16'($urandom), 1'b0);
      end
      begin
        idle(12);
        ready_mode = 1;
      end
    join
    wait_empty();
    send(16'h00F0, 1'b1);
    wait_empty();

    ready_mode = 0;
    send(16'h2468, 1'b0);
    ready_mode = 1;
    send(16'h1357, 1'b0);
    chk("simul_in_ready", 32'(in_ready), 32'd0);
    send(16'hC0DE, 1'b1);
    wait_empty();

    ready_mode = 0;
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    idle(1);
    rst = 1'b0;
    exp_q.delete();
    bits_q.delete();
    exp_phase = 0;
    #1;
    reset_checks("midframe_reset");
    idle(2);
    rst = 1'b1;
    idle(1);

    ready_mode = 2;
    for (int i = 0; i < 150; i++) begin
      idle($urandom_range(0, 2));
      send(16'($urandom), 1'($urandom_range(0, 7) == 0));
    end
    ready_mode = 1;
    wait_empty();
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gearbox_sched.md
# gearbox_sched

Self-contained, flow-controlled 16-to-10-bit width-conversion scheduler for the link interface datapath. It sequences the five-phase 80-bit conversion period, holds the inter-word residue, pads and terminates frames on `in_last`, and queues the produced 10-bit words in a small output FIFO with valid/ready backpressure. It sits between the 16-bit ingress bus and any 10-bit consumer that can stall.

## Interface
- `FIFO_DEPTH`, 4, output queue depth in 10-bit entries; legal range 4..16.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_data`/`in_last` are valid.
- `in_ready`  out  1  the block accepts a word this cycle.
- `in_data`  in  16  input word.
- `in_last`  in  1  the word is the final word of its frame.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  consumer takes the head this cycle.
- `out_data`  out  10  FIFO head word.
- `out_last`  out  1  the head word is the final word of its frame.
- `phase`  out  3  current conversion phase, 0..4.

## Operation
- Bit order is LSB-first. Input word j occupies stream bits [16j+15:16j]; output word k = stream bits [10k+9:10k]. The residue occupies the low bits and new data fills above it.
- Accept: `in_valid & in_ready` at a rising edge.
- The phase counter advances on each accept: 0→1→2→3→4→0. It is unchanged when no word is accepted.
- Each accept produces words, and the following residue bits remain:
  - Phase 0: 1 word, 6 residue bits.
  - Phase 1: 2 words, 2 residue bits.
  - Phase 2: 1 word, 8 residue bits.
  - Phase 3: 2 words, 4 residue bits.
  - Phase 4: 2 words, 0 residue bits.
- Words produced in one accept enter the FIFO in stream order.
- `in_last` accepted:
  - If residue > 0 after the accept, push one extra word: residue zero-extended to 10 bits, with `out_last`=1.
  - Otherwise `out_last`=1 on the last word produced by that accept.
  - Then phase = 0 and residue cleared.
- At most 3 pushes per accept: 2 full words plus 1 pad.
- FIFO:
  - Registered storage. Pop on `out_valid & out_ready`.
  - Push and pop in the same cycle are both honored; count += pushes − pop.
  - No overflow is possible by construction; no underflow pop occurs.
- `in_ready` = (count ≤ FIFO_DEPTH−3). It is derived only from registered count, with no combinational path from `out_ready`.
- `out_valid` = (count ≠ 0). `out_data`/`out_last` come from the head entry; they are 0 when empty.
- Reset (rst=0, asynchronous):
  - `phase`=0, residue=0, count=0, FIFO pointers=0.
  - `out_valid`=0, `out_data`=10'h000, `out_last`=0, `in_ready`=1.
  - A partial frame in flight is discarded; no word of it appears after reset release.

## Timing
- Latency: a word accepted at edge N makes its first produced word visible on the outputs after edge N (only when the FIFO was empty), so it can be popped at edge N+1.
- Sustained throughput is limited by the 1-word/cycle drain. Over one full 5-word period the block produces 8 words, so upstream sees `in_ready` deasserted about 3 of every 8 cycles at full output rate.
- `out_valid`, `out_data` and `out_last` stay stable while `out_valid & ~out_ready`.
- `phase` is registered and reflects the phase the next accepted word will use.
- Reset deassertion is synchronized internally; the first accept is possible at the second rising edge after release.

## Test plan
- Reset: hold rst=0 and toggle inputs → `out_valid`=0, `out_last`=0, `phase`=0, `in_ready`=1; assert rst mid-frame → FIFO empties immediately and `phase`=0.
- Ordering: accept 16'h1234 then 16'h5678 with `out_ready`=1 → outputs 10'h234, 10'h204, 10'h167 in order; `phase`=2.
- Full period: five accepts of 16'hFFFF without last → eight words of 10'h3FF, none with `out_last`; `phase` returns to 0 with residue 0.
- Frame pad: accept single 16'h1234 with `in_last`=1 → 10'h234 (`out_last`=0), then 10'h004 (`out_last`=1); `phase`=0. Phase-4 last (5 words) → no pad word; `out_last` on the 8th word.
- Backpressure: `out_ready`=0, stream words → `in_ready` drops once count > FIFO_DEPTH−3, no entry is lost or duplicated; raise `out_ready` → data is drained in exact stream order.
- Simultaneous push/pop at count = FIFO_DEPTH−3 with a phase-1 accept → count ends at FIFO_DEPTH−2 (pushes 2, pop 1); `in_ready` drops on the next cycle.
